// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath widths, NOP constants and the WB pipeline bus.
package cpu_defs;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 64;
  localparam int HILO_W     = 32;

  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = '0;
  localparam logic [DATA_W-1:0]     ZERO_DWORD    = '0;
  localparam logic [HILO_W-1:0]     ZERO_WORD     = '0;
  localparam logic                  WRITE_ENABLE  = 1'b1;
  localparam logic                  WRITE_DISABLE = 1'b0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [DATA_W-1:0]     wdata;
    logic [HILO_W-1:0]     hi;
    logic [HILO_W-1:0]     lo;
    logic                  whilo;
  } wb_bus_t;

  localparam wb_bus_t WB_BUBBLE = '{
    wd:    NOP_REG_ADDR,
    wreg:  WRITE_DISABLE,
    wdata: ZERO_DWORD,
    hi:    ZERO_WORD,
    lo:    ZERO_WORD,
    whilo: WRITE_DISABLE
  };
endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair; both halves are always written together.
module hilo_reg
  import cpu_defs::*;
#(
  parameter int HILO_W = cpu_defs::HILO_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [HILO_W-1:0] hi_i,
  input  logic [HILO_W-1:0] lo_i,
  output logic [HILO_W-1:0] hi_o,
  output logic [HILO_W-1:0] lo_o
);
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (we) begin
      hi_o <= hi_i;
      lo_o <= lo_i;
    end
  end
endmodule

// File: rtl/mem_wb_hilo.sv
// MEM/WB pipeline register, architectural HI/LO, EX-stage HI/LO forwarding and
// a saturating count of retired regfile writes.
module mem_wb_hilo #(
  parameter int REG_ADDR_W = cpu_defs::REG_ADDR_W,
  parameter int DATA_W     = cpu_defs::DATA_W,
  parameter int HILO_W     = cpu_defs::HILO_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_mem,
  input  logic                  stall_wb,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] mem_wd_i,
  input  logic                  mem_wreg_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  input  logic [HILO_W-1:0]     mem_hi_i,
  input  logic [HILO_W-1:0]     mem_lo_i,
  input  logic                  mem_whilo_i,
  output logic [REG_ADDR_W-1:0] wb_wd_o,
  output logic                  wb_wreg_o,
  output logic [DATA_W-1:0]     wb_wdata_o,
  output logic [HILO_W-1:0]     hi_o,
  output logic [HILO_W-1:0]     lo_o,
  output logic [HILO_W-1:0]     hi_fwd_o,
  output logic [HILO_W-1:0]     lo_fwd_o,
  output logic [31:0]           wb_cnt_o
);
  import cpu_defs::*;

  // Field widths come from cpu_defs; the width parameters must agree with it.
  wb_bus_t     wb_q;
  wb_bus_t     mem_bus;
  logic [31:0] wb_cnt;
  logic        wb_retire;

  assign mem_bus = '{
    wd:    mem_wd_i,
    wreg:  mem_wreg_i,
    wdata: mem_wdata_i,
    hi:    mem_hi_i,
    lo:    mem_lo_i,
    whilo: mem_whilo_i
  };

  // A stalled MEM feeding a moving WB must not replay its request: bubble.
  always_ff @(posedge clk) begin
    if (rst)                        wb_q <= WB_BUBBLE;
    else if (flush)                 wb_q <= WB_BUBBLE;
    else if (stall_mem && !stall_wb) wb_q <= WB_BUBBLE;
    else if (!stall_mem)            wb_q <= mem_bus;
  end

  // Flush does not gate the HI/LO commit: WB contents are already final.
  hilo_reg #(.HILO_W(HILO_W)) u_hilo (
    .clk  (clk),
    .rst  (rst),
    .we   (wb_q.whilo && !stall_wb),
    .hi_i (wb_q.hi),
    .lo_i (wb_q.lo),
    .hi_o (hi_o),
    .lo_o (lo_o)
  );

  always_comb begin
    hi_fwd_o = hi_o;
    lo_fwd_o = lo_o;
    if (mem_whilo_i) begin
      hi_fwd_o = mem_hi_i;
      lo_fwd_o = mem_lo_i;
    end else if (wb_q.whilo) begin
      hi_fwd_o = wb_q.hi;
      lo_fwd_o = wb_q.lo;
    end
  end

  // Writes to r0 are dropped by the regfile, so they do not count as retired.
  assign wb_retire = wb_q.wreg && (wb_q.wd != NOP_REG_ADDR) && !stall_wb;

  always_ff @(posedge clk) begin
    if (rst)                          wb_cnt <= '0;
    else if (wb_retire && ~&wb_cnt)   wb_cnt <= wb_cnt + 32'd1;
  end

  assign wb_wd_o    = wb_q.wd;
  assign wb_wreg_o  = wb_q.wreg;
  assign wb_wdata_o = wb_q.wdata;
  assign wb_cnt_o   = wb_cnt;
endmodule

// File: tb/tb_mem_wb_hilo.sv
// Directed vector bench for mem_wb_hilo: table of per-cycle stimulus/expectations
// plus hand sequences for reset-during-stall and counter saturation.
module tb_mem_wb_hilo;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_mem, stall_wb, flush;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i;
  logic [63:0] mem_wdata_i;
  logic [31:0] mem_hi_i, mem_lo_i;
  logic        mem_whilo_i;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o;
  logic [63:0] wb_wdata_o;
  logic [31:0] hi_o, lo_o, hi_fwd_o, lo_fwd_o, wb_cnt_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_wb_hilo dut (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
    .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i), .mem_whilo_i(mem_whilo_i),
    .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o),
    .hi_o(hi_o), .lo_o(lo_o), .hi_fwd_o(hi_fwd_o), .lo_fwd_o(lo_fwd_o),
    .wb_cnt_o(wb_cnt_o)
  );

  // The controller must never stall WB while MEM advances.
  always @(posedge clk)
    if (rst === 1'b0)
      assert (!(stall_wb && !stall_mem)) else $error("FAIL stall_combo: stall_wb=1 with stall_mem=0");

  typedef struct {
    logic        sm, sw, fl;
    logic [4:0]  wd;
    logic        wreg;
    logic [63:0] wdata;
    logic [31:0] hi, lo;
    logic        whilo;
    logic [31:0] fhi, flo;
    logic [4:0]  ewd;
    logic        ewreg;
    logic [63:0] edata;
    logic [31:0] ehi, elo, ecnt;
  } vec_t;

  vec_t vt[19];

  function automatic vec_t mk(logic sm, logic sw, logic fl, logic [4:0] wd, logic wreg,
                              logic [63:0] wdata, logic [31:0] hi, logic [31:0] lo, logic whilo,
                              logic [31:0] fhi, logic [31:0] flo, logic [4:0] ewd, logic ewreg,
                              logic [63:0] edata, logic [31:0] ehi, logic [31:0] elo,
                              logic [31:0] ecnt);
    vec_t v;
    v.sm = sm; v.sw = sw; v.fl = fl; v.wd = wd; v.wreg = wreg; v.wdata = wdata;
    v.hi = hi; v.lo = lo; v.whilo = whilo; v.fhi = fhi; v.flo = flo;
    v.ewd = ewd; v.ewreg = ewreg; v.edata = edata; v.ehi = ehi; v.elo = elo; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(logic sm, logic sw, logic fl, logic [4:0] wd, logic wreg,
                       logic [63:0] wdata, logic [31:0] hi, logic [31:0] lo, logic whilo);
    stall_mem = sm; stall_wb = sw; flush = fl; mem_wd_i = wd; mem_wreg_i = wreg;
    mem_wdata_i = wdata; mem_hi_i = hi; mem_lo_i = lo; mem_whilo_i = whilo;
  endtask

  localparam logic [63:0] D  = 64'h1234_5678_9ABC_DEF0;
  localparam logic [31:0] H1 = 32'hAAAA_0001, L1 = 32'h5555_0002;
  localparam logic [31:0] HA = 32'h1111_0001, LA = 32'h2222_0002;
  localparam logic [31:0] HB = 32'h3333_0003, LB = 32'h4444_0004;
  localparam logic [31:0] HC = 32'hCCCC_000C, LC = 32'hDDDD_000D;
  localparam logic [31:0] HE = 32'hEEEE_000E, LE = 32'hFFFF_000F;

  initial begin
    //          sm sw fl wd     wreg wdata   hi  lo  wh | fhi flo | ewd   ewreg edata   ehi elo ecnt
    vt[0]  = mk(0, 0, 0, 5'd5, 1, D,      0,  0,  0,  0,  0,  5'd5, 1, D,      0,  0,  1'b0);
    vt[1]  = mk(0, 0, 0, 5'd0, 0, 0,      0,  0,  0,  0,  0,  5'd0, 0, 0,      0,  0,  1);
    vt[2]  = mk(0, 0, 0, 5'd0, 0, 0,      H1, L1, 1,  H1, L1, 5'd0, 0, 0,      0,  0,  1);
    vt[3]  = mk(0, 0, 0, 5'd0, 0, 0,      0,  0,  0,  H1, L1, 5'd0, 0, 0,      H1, L1, 1);
    vt[4]  = mk(0, 0, 0, 5'd0, 0, 0,      HA, LA, 1,  HA, LA, 5'd0, 0, 0,      H1, L1, 1);
    vt[5]  = mk(0, 0, 0, 5'd0, 0, 0,      HB, LB, 1,  HB, LB, 5'd0, 0, 0,      HA, LA, 1);
    vt[6]  = mk(0, 0, 0, 5'd0, 0, 0,      0,  0,  0,  HB, LB, 5'd0, 0, 0,      HB, LB, 1);
    vt[7]  = mk(0, 0, 0, 5'd7, 1, 64'h77, 0,  0,  0,  HB, LB, 5'd7, 1, 64'h77, HB, LB, 1);
    vt[8]  = mk(1, 0, 0, 5'd9, 1, 64'h99, 0,  0,  0,  HB, LB, 5'd0, 0, 0,      HB, LB, 2);
    vt[9]  = mk(0, 0, 0, 5'd10,1, 64'hAA, 0,  0,  0,  HB, LB, 5'd10,1, 64'hAA, HB, LB, 2);
    vt[10] = mk(1, 1, 0, 5'd3, 1, 64'h33, HC, LC, 1,  HC, LC, 5'd10,1, 64'hAA, HB, LB, 2);
    vt[11] = mk(1, 1, 0, 5'd3, 1, 64'h33, HC, LC, 1,  HC, LC, 5'd10,1, 64'hAA, HB, LB, 2);
    vt[12] = mk(1, 1, 0, 5'd3, 1, 64'h33, HC, LC, 1,  HC, LC, 5'd10,1, 64'hAA, HB, LB, 2);
    vt[13] = mk(0, 0, 0, 5'd0, 0, 0,      0,  0,  0,  HB, LB, 5'd0, 0, 0,      HB, LB, 3);
    vt[14] = mk(0, 0, 0, 5'd4, 1, 64'h44, HE, LE, 1,  HE, LE, 5'd4, 1, 64'h44, HB, LB, 3);
    vt[15] = mk(0, 0, 1, 5'd6, 1, 64'h66, 0,  0,  0,  HE, LE, 5'd0, 0, 0,      HE, LE, 4);
    vt[16] = mk(0, 0, 0, 5'd0, 0, 0,      0,  0,  0,  HE, LE, 5'd0, 0, 0,      HE, LE, 4);
    vt[17] = mk(0, 0, 0, 5'd0, 1, 64'h1234,0, 0,  0,  HE, LE, 5'd0, 1, 64'h1234,HE, LE, 4);
    vt[18] = mk(0, 0, 0, 5'd0, 0, 0,      0,  0,  0,  HE, LE, 5'd0, 0, 0,      HE, LE, 4);

    // Reset with arbitrary MEM inputs and stalls.
    rst = 1'b1;
    drive(1, 1, 1, 5'd17, 1, 64'hDEAD_BEEF_0000_1111, 32'h0BAD_F00D, 32'h1357_9BDF, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wd", wb_wd_o, 0);
    chk("rst_wreg", wb_wreg_o, 0);
    chk("rst_wdata", wb_wdata_o, 0);
    chk("rst_hi", hi_o, 0);
    chk("rst_lo", lo_o, 0);
    chk("rst_hi_fwd", hi_fwd_o, 0);
    chk("rst_lo_fwd", lo_fwd_o, 0);
    chk("rst_cnt", wb_cnt_o, 0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].sm, vt[i].sw, vt[i].fl, vt[i].wd, vt[i].wreg, vt[i].wdata,
            vt[i].hi, vt[i].lo, vt[i].whilo);
      #1;
      chk($sformatf("v%0d_hi_fwd", i), hi_fwd_o, vt[i].fhi);
      chk($sformatf("v%0d_lo_fwd", i), lo_fwd_o, vt[i].flo);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wd", i), wb_wd_o, vt[i].ewd);
      chk($sformatf("v%0d_wreg", i), wb_wreg_o, vt[i].ewreg);
      chk($sformatf("v%0d_wdata", i), wb_wdata_o, vt[i].edata);
      chk($sformatf("v%0d_hi", i), hi_o, vt[i].ehi);
      chk($sformatf("v%0d_lo", i), lo_o, vt[i].elo);
      chk($sformatf("v%0d_cnt", i), wb_cnt_o, vt[i].ecnt);
      @(negedge clk);
    end

    // Reset while both stages are stalled with a live WB entry, then resume.
    drive(0, 0, 0, 5'd8, 1, 64'h88, 32'h12, 32'h34, 1);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 0, 5'd8, 1, 64'h88, 32'h12, 32'h34, 0);
    @(posedge clk);
    #1;
    chk("rststall_wd", wb_wd_o, 0);
    chk("rststall_wreg", wb_wreg_o, 0);
    chk("rststall_hi", hi_o, 0);
    chk("rststall_hi_fwd", hi_fwd_o, 0);
    chk("rststall_cnt", wb_cnt_o, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 5'd2, 1, 64'h22, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("resume_wd", wb_wd_o, 5'd2);
    chk("resume_wdata", wb_wdata_o, 64'h22);
    @(negedge clk);
    drive(0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("resume_cnt", wb_cnt_o, 1);

    // Counter saturation from a preloaded value one below the top.
    @(negedge clk);
    force dut.wb_cnt = 32'hFFFF_FFFE;
    drive(0, 0, 0, 5'd1, 1, 64'h11, 0, 0, 0);
    #1;
    release dut.wb_cnt;
    @(posedge clk);
    #1;
    chk("sat_pre", wb_cnt_o, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    chk("sat_top", wb_cnt_o, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    chk("sat_hold", wb_cnt_o, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
